// File: rtl/landscape_pkg.sv
// Shared widths, state encoding and sweep limits for the landscape sweep scheduler.
package landscape_pkg;
    localparam int BIT_ADDR_SHI = 19;
    localparam int BIT_CHIP     = 6;
    localparam int MAX_CHIP     = 2 ** BIT_CHIP;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; prio names the requester that wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);
    logic prio;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After granting 0 the tie goes to 1, and vice versa.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            prio <= 1'b0;
        else if (enable)
            prio <= grant[0];
    end
endmodule

// File: rtl/landscape_sweep_sched.sv
// Arbitrates two sampling engines and sweeps {acc, chip} addresses for the winner's request.
module landscape_sweep_sched #(
    parameter int BIT_ADDR_SHI = landscape_pkg::BIT_ADDR_SHI,
    parameter int BIT_CHIP     = landscape_pkg::BIT_CHIP
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [1:0]                   req_valid,
    input  logic [BIT_ADDR_SHI-1:0]      req_acc0,
    input  logic [BIT_ADDR_SHI-1:0]      req_acc1,
    input  logic [BIT_CHIP:0]            req_nchip,
    output logic [1:0]                   req_ready,
    output logic                         addr_valid,
    output logic [BIT_ADDR_SHI+BIT_CHIP-1:0] addr,
    output logic                         addr_last,
    output logic                         addr_src,
    input  logic                         addr_ready,
    output logic                         busy,
    output logic                         done
);
    import landscape_pkg::*;

    localparam logic [BIT_CHIP:0] CHIP_MAX = {1'b1, {BIT_CHIP{1'b0}}};

    typedef struct packed {
        logic [BIT_ADDR_SHI-1:0] acc;
        logic [BIT_CHIP:0]       nchip;
        logic                    src;
    } sweep_t;

    state_t            state, state_nx;
    sweep_t            cur;
    logic [BIT_CHIP:0] chip_idx;
    logic [BIT_CHIP:0] nchip_clamp;
    logic [1:0]        grant;
    logic              accept;
    logic              beat_acc;
    logic              last_beat;
    logic              sel;

    rr_arb2 u_arb (
        .clk    (clk),
        .clr    (clr),
        .req    (req_valid),
        .enable (accept),
        .grant  (grant)
    );

    assign sel         = grant[1];
    assign accept      = (state == IDLE) && (|(req_valid & grant));
    assign nchip_clamp = (req_nchip > CHIP_MAX) ? CHIP_MAX : req_nchip;
    assign last_beat   = (chip_idx == cur.nchip - 1'b1);
    assign beat_acc    = (state == ISSUE) && addr_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (nchip_clamp == '0) ? DONE : ISSUE;
            ISSUE:   if (beat_acc && last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 2'b00;
        addr_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  req_ready = grant;
            ISSUE: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // chip_idx is one bit wider than the chip field so a full sweep never aliases chip 0.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur      <= '0;
            chip_idx <= '0;
        end else if (accept) begin
            cur.acc   <= sel ? req_acc1 : req_acc0;
            cur.nchip <= nchip_clamp;
            cur.src   <= sel;
            chip_idx  <= '0;
        end else if (beat_acc) begin
            chip_idx <= chip_idx + 1'b1;
        end
    end

    assign addr      = {cur.acc, chip_idx[BIT_CHIP-1:0]};
    assign addr_last = (state == ISSUE) && last_beat;
    assign addr_src  = cur.src;
endmodule

// File: tb/tb_landscape_sweep_sched.sv
// Directed bench: vector table of single sweeps plus backpressure, reset and fairness sequences.
module tb_landscape_sweep_sched;
    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  req_valid;
    logic [18:0] req_acc0, req_acc1;
    logic [6:0]  req_nchip;
    logic [1:0]  req_ready;
    logic        addr_valid;
    logic [24:0] addr;
    logic        addr_last, addr_src, addr_ready, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    landscape_sweep_sched dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_acc0   (req_acc0),
        .req_acc1   (req_acc1),
        .req_nchip  (req_nchip),
        .req_ready  (req_ready),
        .addr_valid (addr_valid),
        .addr       (addr),
        .addr_last  (addr_last),
        .addr_src   (addr_src),
        .addr_ready (addr_ready),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [18:0] a0;
        logic [18:0] a1;
        logic [6:0]  nc;
        logic        src;
        int          beats;
        logic [18:0] exp_acc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_sweep(input vec_t v);
        logic [5:0] ci;
        @(negedge clk);
        req_valid  = v.rv;
        req_acc0   = v.a0;
        req_acc1   = v.a1;
        req_nchip  = v.nc;
        addr_ready = 1'b1;
        #1;
        chk("req_ready", 64'(req_ready), v.src ? 64'h2 : 64'h1);
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs: the running sweep must ignore them.
        req_valid = 2'b00;
        req_acc0  = ~v.a0;
        req_acc1  = ~v.a1;
        req_nchip = 7'd1;
        for (int i = 0; i < v.beats; i++) begin
            ci = i[5:0];
            chk("beat_valid", 64'(addr_valid), 64'h1);
            chk("beat_addr", 64'(addr), 64'({v.exp_acc, ci}));
            chk("beat_last", 64'(addr_last), (i == v.beats - 1) ? 64'h1 : 64'h0);
            chk("beat_src", 64'(addr_src), 64'(v.src));
            chk("beat_busy", 64'(busy), 64'h1);
            @(negedge clk);
        end
        chk("done_pulse", 64'(done), 64'h1);
        chk("done_novalid", 64'(addr_valid), 64'h0);
        chk("done_busy", 64'(busy), 64'h1);
        chk("done_noready", 64'(req_ready), 64'h0);
        @(negedge clk);
        chk("idle_done", 64'(done), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);
    endtask

    initial begin
        int   beat;
        int   k;
        int   w;
        vec_t v;

        vecs[0] = '{2'b01, 19'h12345, 19'h00000, 7'd4,   1'b0, 4,  19'h12345};
        vecs[1] = '{2'b10, 19'h00000, 19'h7ABCD, 7'd3,   1'b1, 3,  19'h7ABCD};
        vecs[2] = '{2'b11, 19'h00001, 19'h00002, 7'd2,   1'b0, 2,  19'h00001};
        vecs[3] = '{2'b11, 19'h00003, 19'h00004, 7'd1,   1'b1, 1,  19'h00004};
        vecs[4] = '{2'b01, 19'h0FFFF, 19'h00000, 7'd0,   1'b0, 0,  19'h0FFFF};
        vecs[5] = '{2'b10, 19'h00000, 19'h7FFFF, 7'd127, 1'b1, 64, 19'h7FFFF};
        vecs[6] = '{2'b01, 19'h55555, 19'h00000, 7'd64,  1'b0, 64, 19'h55555};
        vecs[7] = '{2'b10, 19'h00000, 19'h2AAAA, 7'd65,  1'b1, 64, 19'h2AAAA};

        clr = 1'b1; req_valid = 2'b00; req_acc0 = '0; req_acc1 = '0;
        req_nchip = '0; addr_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(addr_valid), 64'h0);
        chk("rst_addr",  64'(addr),       64'h0);
        chk("rst_last",  64'(addr_last),  64'h0);
        chk("rst_src",   64'(addr_src),   64'h0);
        chk("rst_busy",  64'(busy),       64'h0);
        chk("rst_done",  64'(done),       64'h0);
        chk("rst_ready", 64'(req_ready),  64'h0);
        clr = 1'b0;

        for (int n = 0; n < 8; n++) run_sweep(vecs[n]);

        // Backpressure: addr_ready alternates 1,0,... over a 3-chip sweep.
        @(negedge clk);
        req_valid = 2'b01; req_acc0 = 19'h2468A; req_nchip = 7'd3; addr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        beat = 0; k = 0;
        while (beat < 3 && k < 20) begin
            addr_ready = (k % 2 == 0);
            #1;
            chk("bp_valid", 64'(addr_valid), 64'h1);
            chk("bp_addr",  64'(addr), 64'({19'h2468A, 6'(beat)}));
            chk("bp_last",  64'(addr_last), (beat == 2) ? 64'h1 : 64'h0);
            @(posedge clk);
            if (addr_ready) beat++;
            @(negedge clk);
            k++;
        end
        chk("bp_beats", 64'(beat), 64'd3);
        chk("bp_cycles", 64'(k), 64'd5);
        chk("bp_done", 64'(done), 64'h1);
        addr_ready = 1'b1;
        @(negedge clk);

        // Reset during the third beat of an 8-chip sweep from requester 1.
        @(negedge clk);
        req_valid = 2'b10; req_acc1 = 19'h13579; req_nchip = 7'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            chk("pre_clr_addr", 64'(addr), 64'({19'h13579, 6'(i)}));
            @(negedge clk);
        end
        chk("pre_clr_addr2", 64'(addr), 64'({19'h13579, 6'd2}));
        clr = 1'b1;
        #1;
        chk("clr_valid", 64'(addr_valid), 64'h0);
        chk("clr_addr",  64'(addr),       64'h0);
        chk("clr_last",  64'(addr_last),  64'h0);
        chk("clr_src",   64'(addr_src),   64'h0);
        chk("clr_busy",  64'(busy),       64'h0);
        chk("clr_done",  64'(done),       64'h0);
        @(negedge clk);
        clr = 1'b0;
        v = '{2'b01, 19'h0ABCD, 19'h00000, 7'd2, 1'b0, 2, 19'h0ABCD};
        run_sweep(v);

        // Fairness: both held continuously after reset alternate 0,1,0,1.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        req_valid = 2'b11; req_acc0 = 19'h00AAA; req_acc1 = 19'h00BBB;
        req_nchip = 7'd2; addr_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            w = 0;
            while (!addr_valid && w < 10) begin @(negedge clk); w++; end
            chk("rr_wait", 64'(addr_valid), 64'h1);
            chk("rr_src", 64'(addr_src), 64'(s % 2));
            chk("rr_addr", 64'(addr), (s % 2) ? 64'({19'h00BBB, 6'd0}) : 64'({19'h00AAA, 6'd0}));
            w = 0;
            while (!done && w < 10) begin @(negedge clk); w++; end
            chk("rr_done", 64'(done), 64'h1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
